// File: rtl/run_halt_pkg.sv
// Shared state encoding for the run/halt controller family.
// Values match the legacy state_machine so cs stays compatible.
package run_halt_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_HALT = S_HALT,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/run_cnt.sv
// Work-cycle counter with synchronous clear and a look-ahead hit flag
// that rises when the next increment would reach the job limit.
module run_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] lim,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_inc;

    // One extra bit so the compare never aliases at the top of the range.
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit       = (count_inc == {1'b0, lim});
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_halt_seq.sv
// Run/halt job sequencer: runs a bounded number of work cycles, pauses on
// halt, single-steps while paused and pulses done on completion.
module run_halt_seq
    import run_halt_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic [CNT_W-1:0] limit,
    output logic [1:0]       cs,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic             done_q, done_d;
    logic             clr, inc, hit;

    run_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .lim   (lim_q),
        .count (count),
        .hit   (hit)
    );

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        clr     = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && !halt) begin
                    lim_d   = limit;
                    clr     = 1'b1;
                    state_d = (limit != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    inc = 1'b1;
                    if (hit) state_d = ST_DONE;
                end
            end
            ST_HALT: begin
                if (!halt) begin
                    if (run) begin
                        state_d = ST_RUN;
                    end else if (step) begin
                        inc = 1'b1;
                        if (hit) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A held run must not restart a finished job.
                if (!run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
        end
    end

    assign cs   = state_q;
    assign done = done_q;
    assign busy = (state_q == ST_RUN) || (state_q == ST_HALT);

endmodule

// File: tb/tb_run_halt_seq.sv
// Self-checking bench for run_halt_seq: directed job scenarios followed by
// randomized control traffic, all checked against a cycle-level job model.
module tb_run_halt_seq;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             run, halt, step;
    logic [CNT_W-1:0] limit;
    logic [1:0]       cs;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             busy;

    int checkCount = 0;
    int errorCount = 0;

    // Reference job model: mode 0=idle 1=running 2=paused 3=finished.
    int mMode, mCnt, mLim;
    bit mDone;

    run_halt_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .halt  (halt),
        .step  (step),
        .limit (limit),
        .cs    (cs),
        .count (count),
        .done  (done),
        .busy  (busy)
    );

    always #50 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mCnt  = 0;
        mLim  = 0;
        mDone = 0;
    endtask

    // Advance the job model by one clock edge using the sampled controls.
    task automatic modelAdvance(input bit r, input bit h, input bit s, input int lim);
        int prev;
        prev = mMode;
        case (mMode)
            0: if (r && !h) begin
                mCnt  = 0;
                mLim  = lim;
                mMode = (lim == 0) ? 3 : 1;
            end
            1: if (h) mMode = 2;
               else begin
                   mCnt++;
                   if (mCnt == mLim) mMode = 3;
               end
            2: if (!h) begin
                   if (r) mMode = 1;
                   else if (s) begin
                       mCnt++;
                       if (mCnt == mLim) mMode = 3;
                   end
               end
            default: if (!r) mMode = 0;
        endcase
        mDone = (mMode == 3) && (prev != 3);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".cs"},    32'(cs),    32'(mMode));
        checkOutput({tag, ".count"}, 32'(count), 32'(mCnt));
        checkOutput({tag, ".done"},  32'(done),  32'(mDone));
        checkOutput({tag, ".busy"},  32'(busy),  32'((mMode == 1) || (mMode == 2)));
    endtask

    task automatic applyStimulus(input string tag, input bit r, input bit h, input bit s, input int lim);
        run   = r;
        halt  = h;
        step  = s;
        limit = CNT_W'(lim);
        @(posedge clk);
        modelAdvance(r, h, s, lim);
        #10;
        checkAll(tag);
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        halt  = 1'b0;
        step  = 1'b0;
        limit = '0;
        modelReset();
        #1 reset = 1'b1;
        #1 checkAll("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rst_idle", 0, 0, 0, 0);

        // Plain job of 5 cycles, run held into DONE, then released.
        for (int i = 0; i < 6; i++) applyStimulus("lim5", 1, 0, 0, 5);
        for (int i = 0; i < 3; i++) applyStimulus("lim5_hold", 1, 0, 0, 5);
        applyStimulus("lim5_drop", 0, 0, 0, 5);

        // Pause at count 4, resume and finish.
        for (int i = 0; i < 5; i++) applyStimulus("lim10_run", 1, 0, 0, 10);
        for (int i = 0; i < 5; i++) applyStimulus("lim10_halt", 1, 1, 0, 10);
        for (int i = 0; i < 8; i++) applyStimulus("lim10_resume", 1, 0, 0, 10);
        applyStimulus("lim10_drop", 0, 0, 0, 10);

        // Single-stepping to completion while paused.
        applyStimulus("lim3_start", 1, 0, 0, 3);
        applyStimulus("lim3_inc", 1, 0, 0, 3);
        applyStimulus("lim3_halt", 0, 1, 0, 3);
        applyStimulus("lim3_stepblk", 0, 1, 1, 3);
        applyStimulus("lim3_stepblk", 0, 1, 1, 3);
        applyStimulus("lim3_step1", 0, 0, 1, 3);
        applyStimulus("lim3_gap", 0, 0, 0, 3);
        applyStimulus("lim3_step2", 0, 0, 1, 3);
        applyStimulus("lim3_idle", 0, 0, 0, 3);

        // Zero-length job and halt beating run in IDLE.
        applyStimulus("lim0", 1, 0, 0, 0);
        applyStimulus("lim0_drop", 0, 0, 0, 0);
        applyStimulus("idle_halt", 1, 1, 0, 5);
        applyStimulus("idle_halt", 1, 1, 0, 5);
        applyStimulus("idle_clr", 0, 0, 0, 5);

        // Full-range job; limit changes mid-job are ignored.
        applyStimulus("lim255_start", 1, 0, 0, 255);
        for (int i = 0; i < 256; i++) applyStimulus("lim255", 1, 0, 0, (i < 10) ? 255 : 2);
        applyStimulus("lim255_drop", 0, 0, 0, 2);

        // Asynchronous reset mid-job with count at 3.
        for (int i = 0; i < 4; i++) applyStimulus("rst_mid_run", 1, 0, 0, 10);
        #5 reset = 1'b1;
        #1;
        modelReset();
        checkAll("rst_async");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rst_after", 0, 0, 0, 10);

        // Randomized control traffic over short jobs.
        for (int i = 0; i < 3000; i++) begin
            bit r, h, s;
            int lim;
            r   = ($urandom_range(0, 99) < 60);
            h   = ($urandom_range(0, 99) < 20);
            s   = ($urandom_range(0, 99) < 40);
            lim = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            applyStimulus("rand", r, h, s, lim);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/run_halt_seq.md
Name: run_halt_seq

Overview:
- Parametrised successor to the 2-bit run/halt controller FSM. Adds a bounded run counter, single-step while halted, a terminal DONE state and a done pulse.
- Sequences a job of `limit` work cycles:
  - starts on run;
  - pauses on halt;
  - single-steps on step while paused;
  - reports completion.
- Sits between the top-level control inputs and any datapath needing a gated cycle count.

Parameters:
- CNT_W, 8, width of count and limit. Legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  start / resume request, level-sensitive.
- halt  input  1  pause request, level-sensitive; highest priority after reset.
- step  input  1  single-step request, honoured only in HALT.
- limit  input  CNT_W  number of work cycles per job; sampled on job start.
- cs  output  2  current state: 0=IDLE, 1=RUN, 2=HALT, 3=DONE.
- count  output  CNT_W  work cycles completed in current/last job.
- done  output  1  one-cycle pulse on entry to DONE.
- busy  output  1  high when cs is RUN or HALT.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, async assert, any time including mid-job:
  - cs=0, count=0, done=0, busy=0, internal lim_q=0.
  - First edge after deassert evaluates from IDLE.
- All outputs are registered or decoded from registered state. busy is decoded from cs. No combinational input->output paths.
- IDLE:
  - run=1, halt=0, limit!=0 -> RUN; lim_q<=limit; count<=0.
  - run=1, halt=0, limit==0 -> DONE directly; count stays 0; done=1.
  - halt=1 -> stay IDLE; halt beats run.
  - Otherwise stay.
- RUN, checked in this order:
  - halt=1 -> HALT; count holds, no increment that cycle.
  - Else count<=count+1. If count+1==lim_q -> DONE; otherwise stay RUN.
  - run deasserting in RUN does not stop the job; only halt pauses it.
- HALT, checked in this order:
  - halt=1 -> stay; step ignored.
  - halt=0, run=1 -> RUN; no increment on the transition edge.
  - halt=0, run=0, step=1 -> count<=count+1. Go DONE if count+1==lim_q, else stay HALT.
  - step is level-sensitive: each cycle it is held performs one step.
  - Otherwise stay HALT.
- DONE:
  - done=1 only in the first cycle cs==3; 0 thereafter.
  - count holds its final value.
  - run=0 -> IDLE, with count held until the next start. run=1 -> stay, so a held run never restarts a job.
- Latency:
  - run sampled at edge N gives cs=1 after edge N.
  - A job of L cycles with no halts shows cs=3 exactly L edges after entering RUN.
- Width rules:
  - count never exceeds lim_q <= 2^CNT_W-1, so it cannot wrap.
  - Compare uses count+1 at CNT_W+1 bits.
- limit changes during RUN, HALT or DONE have no effect.

Decomposition:
- Shared package run_halt_pkg:
  - state localparams S_IDLE=2'd0, S_RUN=2'd1, S_HALT=2'd2, S_DONE=2'd3.
  - Shared with the legacy state_machine encoding so cs values stay compatible.
- One sub-module: run_cnt, a CNT_W-wide counter with inputs clr, inc, lim and output hit, where hit = (count+1==lim). The FSM instantiates it once.

Test Plan (CNT_W=8, 100 ns clock):
- Reset at t=1 with run=halt=0, then release -> cs=0, count=0, done=0, busy=0. Assert reset again mid-RUN with count=3 -> all outputs zero immediately, before the next clk edge.
- limit=5, run=1 held -> cs=1 for 5 cycles, count 1..5, then cs=3 with done=1 for exactly one cycle. Hold run 3 more cycles -> cs stays 3, count=5. Drop run -> cs=0 next edge.
- limit=10, run=1; halt=1 after count=4 for 5 cycles -> cs=2, count frozen at 4. halt=0, run=1 -> cs=1, count reaches 10, done pulse.
- limit=3, enter HALT at count=1; halt=0, run=0, step pulsed 1 cycle twice -> count 2, then 3 with cs=3 and done=1. step with halt=1 -> count unchanged.
- limit=0, run=1 -> cs=3, done=1 next edge, count=0. run=1 and halt=1 together in IDLE -> stays cs=0.
- limit=255, run=1 -> count reaches 255 without wrap, cs=3. Changing limit to 2 mid-job -> no effect.
